// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: per-stage register/control taps in,
// stall/flush/forward controls and perf counters out.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned AW    = 5,
    parameter int unsigned CNT_W = 32
);
    logic [AW-1:0]    rs1_id_i, rs2_id_i;
    logic             rs1_used_id_i, rs2_used_id_i;
    logic [AW-1:0]    rs1_ex_i, rs2_ex_i, rd_ex_i;
    logic             regwrite_ex_i, memread_ex_i;
    logic [AW-1:0]    rd_mem_i;
    logic             regwrite_mem_i;
    logic [AW-1:0]    rd_wb_i;
    logic             regwrite_wb_i;
    logic             branch_taken_i;
    logic             clr_cnt_i;
    logic             pc_write_o, ifid_write_o, idex_bubble_o, ifid_flush_o;
    logic [1:0]       fwd_a_o, fwd_b_o;
    logic             fwd_id_rs1_o, fwd_id_rs2_o;
    logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;

    modport master (
        output rs1_id_i, rs2_id_i, rs1_used_id_i, rs2_used_id_i,
               rs1_ex_i, rs2_ex_i, rd_ex_i, regwrite_ex_i, memread_ex_i,
               rd_mem_i, regwrite_mem_i, rd_wb_i, regwrite_wb_i,
               branch_taken_i, clr_cnt_i,
        input  pc_write_o, ifid_write_o, idex_bubble_o, ifid_flush_o,
               fwd_a_o, fwd_b_o, fwd_id_rs1_o, fwd_id_rs2_o,
               stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  rs1_id_i, rs2_id_i, rs1_used_id_i, rs2_used_id_i,
               rs1_ex_i, rs2_ex_i, rd_ex_i, regwrite_ex_i, memread_ex_i,
               rd_mem_i, regwrite_mem_i, rd_wb_i, regwrite_wb_i,
               branch_taken_i, clr_cnt_i,
        output pc_write_o, ifid_write_o, idex_bubble_o, ifid_flush_o,
               fwd_a_o, fwd_b_o, fwd_id_rs1_o, fwd_id_rs2_o,
               stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage pipe: EX and ID forwarding,
// load-use interlock of LOAD_LAT cycles, taken-branch flush, perf counters.
module pipe_hazard_ctrl #(
    parameter int unsigned AW       = 5,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned BR_STAGE = 2,
    parameter int unsigned CNT_W    = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    pipe_hazard_ctrl_if.slave hz
);
    localparam int unsigned   SCNT_W = 2;
    localparam logic [AW-1:0] X0     = '0;

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_e;

    state_e             state_q, state_d;
    logic [SCNT_W-1:0]  scnt_q, scnt_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic               lu, stall, flush, bubble;
    logic [1:0]         fwd_a, fwd_b;
    logic               fwd_id1, fwd_id2;

    // EX/MEM result wins over the older MEM/WB result
    function automatic logic [1:0] ex_sel(input logic [AW-1:0] rs,
                                          input logic [AW-1:0] rd_mem, input logic we_mem,
                                          input logic [AW-1:0] rd_wb,  input logic we_wb);
        logic [1:0] sel;
        sel = 2'b00;
        if (we_mem && rd_mem != X0 && rd_mem == rs)   sel = 2'b10;
        else if (we_wb && rd_wb != X0 && rd_wb == rs) sel = 2'b01;
        return sel;
    endfunction

    always_comb begin
        fwd_a   = ex_sel(hz.rs1_ex_i, hz.rd_mem_i, hz.regwrite_mem_i, hz.rd_wb_i, hz.regwrite_wb_i);
        fwd_b   = ex_sel(hz.rs2_ex_i, hz.rd_mem_i, hz.regwrite_mem_i, hz.rd_wb_i, hz.regwrite_wb_i);
        fwd_id1 = hz.regwrite_wb_i && hz.rd_wb_i != X0 && hz.rd_wb_i == hz.rs1_id_i;
        fwd_id2 = hz.regwrite_wb_i && hz.rd_wb_i != X0 && hz.rd_wb_i == hz.rs2_id_i;
        lu      = hz.memread_ex_i && hz.regwrite_ex_i && hz.rd_ex_i != X0 &&
                  ((hz.rs1_used_id_i && hz.rd_ex_i == hz.rs1_id_i) ||
                   (hz.rs2_used_id_i && hz.rd_ex_i == hz.rs2_id_i));
    end

    // Stall FSM next-state plus branch flush arbitration
    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        stall   = 1'b0;
        flush   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (lu) begin
                    stall = 1'b1;
                    if (LOAD_LAT > 1) begin
                        scnt_d  = SCNT_W'(LOAD_LAT - 1);
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                stall  = 1'b1;
                scnt_d = scnt_q - SCNT_W'(1);
                if (scnt_d == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A branch resolved in EX squashes the stalled consumer in ID
        if (BR_STAGE == 2) begin
            if (hz.branch_taken_i) begin
                stall   = 1'b0;
                flush   = 1'b1;
                state_d = IDLE;
                scnt_d  = '0;
            end
        end else begin
            flush = hz.branch_taken_i && !stall;
        end
        bubble = stall || (flush && BR_STAGE == 2);
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (hz.clr_cnt_i) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
            if (flush && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            scnt_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            scnt_q      <= scnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Combinational controls are held at their idle values during reset
    assign hz.pc_write_o    = rst_i || !stall;
    assign hz.ifid_write_o  = rst_i || !stall;
    assign hz.idex_bubble_o = !rst_i && bubble;
    assign hz.ifid_flush_o  = !rst_i && flush;
    assign hz.fwd_a_o       = rst_i ? 2'b00 : fwd_a;
    assign hz.fwd_b_o       = rst_i ? 2'b00 : fwd_b;
    assign hz.fwd_id_rs1_o  = !rst_i && fwd_id1;
    assign hz.fwd_id_rs2_o  = !rst_i && fwd_id2;
    assign hz.stall_cnt_o   = stall_cnt_q;
    assign hz.flush_cnt_o   = flush_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Drives three controller configurations (LL1/BR2, LL2/BR2, LL2/BR1, 4-bit
// counters) from shared stimulus and checks them against a cycle model.
module tb_pipe_hazard_ctrl;
    localparam int unsigned ND   = 3;
    localparam int unsigned CW   = 4;
    localparam int          CMAX = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, br, clr;
    logic [4:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
    logic       rs1_used, rs2_used, regwrite_ex, memread_ex, regwrite_mem, regwrite_wb;

    logic [ND-1:0]         obs_pcw, obs_ifw, obs_bub, obs_fl, obs_i1, obs_i2;
    logic [ND-1:0][1:0]    obs_fa, obs_fb;
    logic [ND-1:0][CW-1:0] obs_sc, obs_fc;

    int errors = 0;
    int checks = 0;

    // reference model: remaining stall cycles and saturating counts
    int         rem [ND];
    int         sc_m [ND];
    int         fc_m [ND];
    logic [ND-1:0] e_stall, e_flush, e_bub;
    logic [1:0] e_fa, e_fb;
    logic       e_i1, e_i2;

    for (genvar g = 0; g < ND; g++) begin : gd
        pipe_hazard_ctrl_if #(.AW(5), .CNT_W(CW)) hif ();
        assign hif.rs1_id_i       = rs1_id;
        assign hif.rs2_id_i       = rs2_id;
        assign hif.rs1_used_id_i  = rs1_used;
        assign hif.rs2_used_id_i  = rs2_used;
        assign hif.rs1_ex_i       = rs1_ex;
        assign hif.rs2_ex_i       = rs2_ex;
        assign hif.rd_ex_i        = rd_ex;
        assign hif.regwrite_ex_i  = regwrite_ex;
        assign hif.memread_ex_i   = memread_ex;
        assign hif.rd_mem_i       = rd_mem;
        assign hif.regwrite_mem_i = regwrite_mem;
        assign hif.rd_wb_i        = rd_wb;
        assign hif.regwrite_wb_i  = regwrite_wb;
        assign hif.branch_taken_i = br;
        assign hif.clr_cnt_i      = clr;

        pipe_hazard_ctrl #(
            .AW(5), .LOAD_LAT((g == 0) ? 1 : 2), .BR_STAGE((g == 2) ? 1 : 2), .CNT_W(CW)
        ) u_dut (
            .clk_i(clk), .rst_i(rst), .hz(hif)
        );

        assign obs_pcw[g] = hif.pc_write_o;
        assign obs_ifw[g] = hif.ifid_write_o;
        assign obs_bub[g] = hif.idex_bubble_o;
        assign obs_fl[g]  = hif.ifid_flush_o;
        assign obs_fa[g]  = hif.fwd_a_o;
        assign obs_fb[g]  = hif.fwd_b_o;
        assign obs_i1[g]  = hif.fwd_id_rs1_o;
        assign obs_i2[g]  = hif.fwd_id_rs2_o;
        assign obs_sc[g]  = hif.stall_cnt_o;
        assign obs_fc[g]  = hif.flush_cnt_o;
    end

    function automatic int ll_of(int d);  return (d == 0) ? 1 : 2; endfunction
    function automatic int bst_of(int d); return (d == 2) ? 1 : 2; endfunction

    function automatic logic [1:0] src_of(logic [4:0] r);
        if (regwrite_mem && rd_mem != 0 && rd_mem == r) return 2'b10;
        if (regwrite_wb && rd_wb != 0 && rd_wb == r)    return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic lu_now();
        return memread_ex && regwrite_ex && rd_ex != 0 &&
               ((rs1_used && rd_ex == rs1_id) || (rs2_used && rd_ex == rs2_id));
    endfunction

    task automatic idle_inputs();
        {rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb} = '0;
        {rs1_used, rs2_used, regwrite_ex, memread_ex, regwrite_mem, regwrite_wb} = '0;
        br = 1'b0; clr = 1'b0;
    endtask

    task automatic set_load_use(logic [4:0] r);
        memread_ex = 1'b1; regwrite_ex = 1'b1; rd_ex = r; rs1_id = r; rs1_used = 1'b1;
    endtask

    task automatic model_eval();
        logic want;
        for (int d = 0; d < ND; d++) begin
            want = (rem[d] > 0) || lu_now();
            if (rst) begin
                e_stall[d] = 1'b0; e_flush[d] = 1'b0; e_bub[d] = 1'b0;
            end else if (bst_of(d) == 2 && br) begin
                e_stall[d] = 1'b0; e_flush[d] = 1'b1; e_bub[d] = 1'b1;
            end else begin
                e_stall[d] = want;
                e_flush[d] = (bst_of(d) == 1) && br && !want;
                e_bub[d]   = want;
            end
        end
        e_fa = rst ? 2'b00 : src_of(rs1_ex);
        e_fb = rst ? 2'b00 : src_of(rs2_ex);
        e_i1 = !rst && regwrite_wb && rd_wb != 0 && rd_wb == rs1_id;
        e_i2 = !rst && regwrite_wb && rd_wb != 0 && rd_wb == rs2_id;
    endtask

    // advances the model across one rising edge; inputs are changed 1 unit later
    task automatic advance();
        model_eval();
        @(posedge clk);
        for (int d = 0; d < ND; d++) begin
            if (rst) begin
                rem[d] = 0; sc_m[d] = 0; fc_m[d] = 0;
            end else begin
                if (clr) begin
                    sc_m[d] = 0; fc_m[d] = 0;
                end else begin
                    if (e_stall[d] && sc_m[d] < CMAX) sc_m[d]++;
                    if (e_flush[d] && fc_m[d] < CMAX) fc_m[d]++;
                end
                if (bst_of(d) == 2 && br) rem[d] = 0;
                else if (rem[d] > 0)      rem[d] = rem[d] - 1;
                else if (lu_now())        rem[d] = ll_of(d) - 1;
                else                      rem[d] = 0;
            end
        end
        #1;
    endtask

    task automatic clear_counters();
        idle_inputs();
        clr = 1'b1;
        advance();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        regwrite_mem = 1'b1; rd_mem = 5'd5; rs1_ex = 5'd5;
        regwrite_wb = 1'b1; rd_wb = 5'd6; rs1_id = 5'd6;
        set_load_use(5'd6);
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (obs_pcw[d] !== 1'b1 || obs_ifw[d] !== 1'b1 || obs_bub[d] !== 1'b0 || obs_fl[d] !== 1'b0 ||
                obs_fa[d] !== 2'b00 || obs_fb[d] !== 2'b00 || obs_i1[d] !== 1'b0 || obs_i2[d] !== 1'b0 ||
                obs_sc[d] !== 4'd0 || obs_fc[d] !== 4'd0) begin
                errors++;
                $display("FAIL reset dut%0d got pcw=%b ifw=%b bub=%b fl=%b fa=%b fb=%b i1=%b sc=%0d fc=%0d required 1 1 0 0 00 00 0 0 0",
                         d, obs_pcw[d], obs_ifw[d], obs_bub[d], obs_fl[d], obs_fa[d], obs_fb[d], obs_i1[d], obs_sc[d], obs_fc[d]);
            end
        end
        advance();
        rst = 1'b0;
        idle_inputs();
    endtask

    task automatic test_forwarding();
        logic [1:0] xa, xb;
        logic       x1, x2;
        for (int i = 0; i < 4; i++) begin
            idle_inputs();
            case (i)
                0: begin regwrite_mem = 1; rd_mem = 5; rs1_ex = 5; regwrite_wb = 1; rd_wb = 6; rs2_ex = 6;
                         rs1_id = 6; rs2_id = 7; xa = 2'b10; xb = 2'b01; x1 = 1; x2 = 0; end
                1: begin regwrite_mem = 1; rd_mem = 7; regwrite_wb = 1; rd_wb = 7; rs1_ex = 7; rs2_ex = 7;
                         rs1_id = 3; rs2_id = 7; xa = 2'b10; xb = 2'b10; x1 = 0; x2 = 1; end
                2: begin regwrite_mem = 1; regwrite_wb = 1; xa = 2'b00; xb = 2'b00; x1 = 0; x2 = 0; end
                default: begin rd_mem = 9; rs1_ex = 9; regwrite_wb = 1; rd_wb = 9; rs2_ex = 4;
                         rs1_id = 9; rs2_id = 3; xa = 2'b01; xb = 2'b00; x1 = 1; x2 = 0; end
            endcase
            @(negedge clk);
            for (int d = 0; d < ND; d++) begin
                checks++;
                if (obs_fa[d] !== xa || obs_fb[d] !== xb || obs_i1[d] !== x1 || obs_i2[d] !== x2) begin
                    errors++;
                    $display("FAIL fwd case%0d dut%0d got a=%b b=%b id1=%b id2=%b required a=%b b=%b id1=%b id2=%b",
                             i, d, obs_fa[d], obs_fb[d], obs_i1[d], obs_i2[d], xa, xb, x1, x2);
                end
            end
            advance();
        end
        idle_inputs();
    endtask

    task automatic test_load_use();
        int xs;
        clear_counters();
        for (int c = 0; c < 3; c++) begin
            idle_inputs();
            if (c == 0) set_load_use(5'd3);
            if (c == 2) begin regwrite_wb = 1; rd_wb = 3; rs1_id = 3; rs1_used = 1; end
            @(negedge clk);
            model_eval();
            for (int d = 0; d < ND; d++) begin
                checks++;
                if (obs_pcw[d] !== !e_stall[d] || obs_ifw[d] !== !e_stall[d] || obs_bub[d] !== e_bub[d]) begin
                    errors++;
                    $display("FAIL load_use c%0d dut%0d got pcw=%b ifw=%b bub=%b required pcw=%b bub=%b",
                             c, d, obs_pcw[d], obs_ifw[d], obs_bub[d], !e_stall[d], e_bub[d]);
                end
                if (c == 2) begin
                    xs = ll_of(d);
                    checks++;
                    if (obs_sc[d] !== 4'(xs) || obs_i1[d] !== 1'b1) begin
                        errors++;
                        $display("FAIL load_use_count dut%0d got stall_cnt=%0d id1=%b required %0d 1",
                                 d, obs_sc[d], obs_i1[d], xs);
                    end
                end
            end
            advance();
        end
        idle_inputs();
    endtask

    task automatic test_branch_override();
        clear_counters();
        set_load_use(5'd8);
        br = 1'b1;
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (obs_fl[d] !== (d != 2) || obs_pcw[d] !== (d != 2) || obs_bub[d] !== 1'b1) begin
                errors++;
                $display("FAIL branch_cycle dut%0d got flush=%b pcw=%b bub=%b required %b %b 1",
                         d, obs_fl[d], obs_pcw[d], obs_bub[d], d != 2, d != 2);
            end
        end
        advance();
        idle_inputs();
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (obs_pcw[d] !== (d != 2) || obs_fc[d] !== 4'((d != 2) ? 1 : 0)) begin
                errors++;
                $display("FAIL branch_after dut%0d got pcw=%b flush_cnt=%0d required %b %0d",
                         d, obs_pcw[d], obs_fc[d], d != 2, (d != 2) ? 1 : 0);
            end
        end
        advance();
        advance();
    endtask

    task automatic test_no_stall();
        for (int i = 0; i < 2; i++) begin
            idle_inputs();
            memread_ex = 1; regwrite_ex = 1;
            if (i == 0) begin rd_ex = 0; rs1_id = 0; rs1_used = 1; end
            else begin rd_ex = 4; rs1_id = 4; rs1_used = 0; rs2_id = 5; rs2_used = 1; end
            @(negedge clk);
            for (int d = 0; d < ND; d++) begin
                checks++;
                if (obs_pcw[d] !== 1'b1 || obs_bub[d] !== 1'b0) begin
                    errors++;
                    $display("FAIL no_stall case%0d dut%0d got pcw=%b bub=%b required 1 0", i, d, obs_pcw[d], obs_bub[d]);
                end
            end
            advance();
        end
        idle_inputs();
    endtask

    task automatic test_reset_in_hold();
        set_load_use(5'd2);
        advance();
        idle_inputs();
        rst = 1'b1;
        #1;
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (obs_pcw[d] !== 1'b1 || obs_ifw[d] !== 1'b1 || obs_bub[d] !== 1'b0 || obs_sc[d] !== 4'd0) begin
                errors++;
                $display("FAIL reset_hold dut%0d got pcw=%b ifw=%b bub=%b sc=%0d required 1 1 0 0",
                         d, obs_pcw[d], obs_ifw[d], obs_bub[d], obs_sc[d]);
            end
        end
        advance();
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (obs_pcw[d] !== 1'b1) begin
                errors++;
                $display("FAIL reset_hold_after dut%0d got pcw=%b required 1", d, obs_pcw[d]);
            end
        end
        advance();
    endtask

    task automatic test_saturation();
        clear_counters();
        set_load_use(5'd9);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            model_eval();
            for (int d = 0; d < ND; d++) begin
                checks++;
                if (obs_pcw[d] !== !e_stall[d]) begin
                    errors++;
                    $display("FAIL sat_stall c%0d dut%0d got pcw=%b required %b", c, d, obs_pcw[d], !e_stall[d]);
                end
            end
            advance();
        end
        clr = 1'b1;
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (obs_sc[d] !== 4'd15) begin
                errors++;
                $display("FAIL sat_hold dut%0d got stall_cnt=%0d required 15", d, obs_sc[d]);
            end
        end
        advance();
        clr = 1'b0;
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (obs_sc[d] !== 4'd0) begin
                errors++;
                $display("FAIL clear_vs_stall dut%0d got stall_cnt=%0d required 0", d, obs_sc[d]);
            end
        end
        advance();
        idle_inputs();
        advance();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rs1_id = 5'($urandom_range(0, 3)); rs2_id = 5'($urandom_range(0, 3));
            rs1_ex = 5'($urandom_range(0, 3)); rs2_ex = 5'($urandom_range(0, 3));
            rd_ex  = 5'($urandom_range(0, 3)); rd_mem = 5'($urandom_range(0, 3));
            rd_wb  = 5'($urandom_range(0, 3));
            rs1_used = 1'($urandom); rs2_used = 1'($urandom);
            regwrite_ex = 1'($urandom); memread_ex = 1'($urandom);
            regwrite_mem = 1'($urandom); regwrite_wb = 1'($urandom);
            br  = ($urandom_range(0, 7) == 0);
            clr = ($urandom_range(0, 39) == 0);
            @(negedge clk);
            model_eval();
            for (int d = 0; d < ND; d++) begin
                checks++;
                if (obs_pcw[d] !== !e_stall[d] || obs_ifw[d] !== !e_stall[d] || obs_bub[d] !== e_bub[d] ||
                    obs_fl[d] !== e_flush[d] || obs_fa[d] !== e_fa || obs_fb[d] !== e_fb ||
                    obs_i1[d] !== e_i1 || obs_i2[d] !== e_i2 ||
                    obs_sc[d] !== 4'(sc_m[d]) || obs_fc[d] !== 4'(fc_m[d])) begin
                    errors++;
                    $display("FAIL random c%0d dut%0d got pcw=%b bub=%b fl=%b fa=%b fb=%b i1=%b i2=%b sc=%0d fc=%0d required pcw=%b bub=%b fl=%b fa=%b fb=%b i1=%b i2=%b sc=%0d fc=%0d",
                             c, d, obs_pcw[d], obs_bub[d], obs_fl[d], obs_fa[d], obs_fb[d], obs_i1[d], obs_i2[d],
                             obs_sc[d], obs_fc[d], !e_stall[d], e_bub[d], e_flush[d], e_fa, e_fb, e_i1, e_i2,
                             sc_m[d], fc_m[d]);
                end
            end
            advance();
        end
        idle_inputs();
    endtask

    initial begin
        for (int d = 0; d < ND; d++) begin rem[d] = 0; sc_m[d] = 0; fc_m[d] = 0; end
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch_override();
        test_no_stall();
        test_reset_in_hold();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised hazard and forwarding controller for the 5-stage pipelined CPU (IF/ID/EX/MEM/WB).
- Drives the EX-stage operand forwarding muxes (3:1) and the ID-stage register-file write-through muxes (2:1).
- Adds what the current datapath lacks: a load-use interlock with configurable stall length, taken-branch flush at a configurable resolution stage, and saturating stall/flush performance counters.

Parameters:
- AW, 5, register address width.
- LOAD_LAT, 1, load-use bubble cycles (1 = combinational data memory, 2 = registered data memory); legal values 1..2.
- BR_STAGE, 2, stage resolving branches (1 = ID, 2 = EX).
- CNT_W, 32, performance counter width.

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  asynchronous, active-high reset
- rs1_id_i, rs2_id_i  in  AW  source registers of instruction in ID
- rs1_used_id_i, rs2_used_id_i  in  1  ID instruction actually reads rs1/rs2
- rs1_ex_i, rs2_ex_i  in  AW  source registers latched in ID/EX
- rd_ex_i  in  AW  destination in ID/EX
- regwrite_ex_i, memread_ex_i  in  1  ID/EX control
- rd_mem_i  in  AW  destination in EX/MEM
- regwrite_mem_i  in  1  EX/MEM RegWrite
- rd_wb_i  in  AW  destination in MEM/WB
- regwrite_wb_i  in  1  MEM/WB RegWrite
- branch_taken_i  in  1  taken branch/jump resolved in stage BR_STAGE
- clr_cnt_i  in  1  synchronous counter clear
- pc_write_o  out  1  PC update enable
- ifid_write_o  out  1  IF/ID load enable
- idex_bubble_o  out  1  zero ID/EX control fields next edge
- ifid_flush_o  out  1  replace IF/ID with NOP next edge
- fwd_a_o, fwd_b_o  out  2  EX operand select: 00 ID/EX, 01 MEM/WB, 10 EX/MEM
- fwd_id_rs1_o, fwd_id_rs2_o  out  1  ID write-through from WB data
- stall_cnt_o  out  CNT_W  cycles with stall asserted
- flush_cnt_o  out  CNT_W  flush events

Behaviour:
- Reset (async, while rst_i=1):
  - state IDLE, stall counter 0, perf counters 0.
  - pc_write_o=1, ifid_write_o=1, idex_bubble_o=0, ifid_flush_o=0, fwd_a_o=fwd_b_o=00, fwd_id_*=0.
- EX forwarding (combinational), fwd_a_o shown; fwd_b_o is identical with rs2_ex_i:
  - 10 if regwrite_mem_i && rd_mem_i!=0 && rd_mem_i==rs1_ex_i;
  - else 01 if regwrite_wb_i && rd_wb_i!=0 && rd_wb_i==rs1_ex_i;
  - else 00.
  - EX/MEM has priority over MEM/WB.
- ID write-through: fwd_id_rs1_o = regwrite_wb_i && rd_wb_i!=0 && rd_wb_i==rs1_id_i; rs2 likewise.
- Load-use detect (lu): memread_ex_i && regwrite_ex_i && rd_ex_i!=0 && ((rs1_used_id_i && rd_ex_i==rs1_id_i) || (rs2_used_id_i && rd_ex_i==rs2_id_i)).
- Stall FSM, states IDLE and HOLD, down-counter scnt (2 bits):
  - IDLE: on lu, stall this cycle; if LOAD_LAT=2, scnt<=1 and go to HOLD; else stay IDLE.
  - HOLD: stall this cycle; scnt decrements; return to IDLE when scnt reaches 0.
  - Total stall length = LOAD_LAT cycles per load-use.
  - During stall: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1.
- Flush:
  - BR_STAGE=1: branch_taken_i raises ifid_flush_o; it is ignored while stalled, since the branch operands are not ready.
  - BR_STAGE=2: branch_taken_i raises ifid_flush_o and idex_bubble_o and overrides any stall. pc_write_o=1, ifid_write_o=1, FSM forced to IDLE and scnt cleared at the next edge, because the stalled consumer has been squashed.
- Counters:
  - stall_cnt_o increments each cycle pc_write_o=0.
  - flush_cnt_o increments each cycle ifid_flush_o=1.
  - Both saturate at all-ones and do not wrap.
  - clr_cnt_i zeroes both next edge; clear beats increment when both occur in the same cycle.
- x0 never triggers forwarding or a stall.

Test Plan:
- add x5 in MEM, sub reads x5 in EX; same cycle add x6 in WB, sub's rs2=x6 -> fwd_a_o=10, fwd_b_o=01.
- x7 written in both MEM and WB, EX reads x7 -> fwd_a_o=10 (priority).
- LOAD_LAT=1: lw x3 in EX, ID add reads x3 -> one cycle with pc_write_o=0, idex_bubble_o=1, stall_cnt_o=1. LOAD_LAT=2: same stimulus -> two stall cycles, stall_cnt_o=2, third cycle fwd_id_rs1_o=1.
- BR_STAGE=2, LOAD_LAT=2: branch_taken_i in the first stall cycle -> that cycle ifid_flush_o=1 and pc_write_o=1; next cycle FSM is IDLE with no stall; flush_cnt_o=1.
- Load-use to x0, or rs1_used_id_i=0 -> no stall; rst_i pulsed while in HOLD -> outputs immediately return to reset values.
- CNT_W=4, 20 stall cycles -> stall_cnt_o holds at 15; clr_cnt_i concurrent with a stall -> 0.
